alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, a serial shift-add multiplier and an optional
// serial restoring divider (enabled by defining ALU_SEQ_DIV_EN).
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpAnd   = 4'd2;
    localparam logic [3:0] OpOr    = 4'd3;
    localparam logic [3:0] OpSltu  = 4'd4;
    localparam logic [3:0] OpSll   = 4'd5;
    localparam logic [3:0] OpSrl   = 4'd6;
    localparam logic [3:0] OpSra   = 4'd7;
    localparam logic [3:0] OpSlt   = 4'd8;
    localparam logic [3:0] OpMul   = 4'd9;
    localparam logic [3:0] OpMulhu = 4'd10;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OpDivu  = 4'd11;
    localparam logic [3:0] OpRemu  = 4'd12;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } state_e;

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    cnt_q;
    logic             eq_q;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;

    always_comb begin
        alu_res = a + b;
        case (op)
            OpAdd:   alu_res = a + b;
            OpSub:   alu_res = a - b;
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OpSll:   alu_res = b << shamt;
            OpSrl:   alu_res = b >> shamt;
            OpSra:   alu_res = $signed(b) >>> shamt;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = a + b;
        endcase
    end

    // hi_q accumulates partial products while lo_q shifts the multiplier out of bit 0.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   div_part;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;

    // A zero divisor always "fits", which yields quotient all-ones and remainder a for free.
    always_comb begin
        div_part = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_part[WIDTH-1:0] - opnd_q;
        div_ge   = (div_part >= {1'b0, opnd_q});
        div_hi_n = div_ge ? div_diff : div_part[WIDTH-1:0];
        div_lo_n = {lo_q[WIDTH-2:0], div_ge};
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 4'd0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q  <= op;
                        eq_q  <= (a == b);
                        cnt_q <= '0;
                        if (op == OpMul || op == OpMulhu) begin
                            state_q <= StMul;
                            opnd_q  <= a;
                            hi_q    <= '0;
                            lo_q    <= b;
                        end
`ifdef ALU_SEQ_DIV_EN
                        else if (op == OpDivu || op == OpRemu) begin
                            state_q <= StDiv;
                            opnd_q  <= b;
                            hi_q    <= '0;
                            lo_q    <= a;
                        end
`endif
                        else begin
                            state_q <= StDone;
                            result  <= alu_res;
                            zero    <= (a == b);
                        end
                    end
                end
                StMul: begin
                    hi_q  <= mul_hi_n;
                    lo_q  <= mul_lo_n;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= StDone;
                        result  <= (op_q == OpMulhu) ? mul_hi_n : mul_lo_n;
                        zero    <= eq_q;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                StDiv: begin
                    hi_q  <= div_hi_n;
                    lo_q  <= div_lo_n;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= StDone;
                        result  <= (op_q == OpRemu) ? div_hi_n : div_lo_n;
                        zero    <= eq_q;
                    end
                end
`endif
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready = (state_q == StIdle);
    assign done  = (state_q == StDone);

endmodule
